// File: rtl/mem_resp.sv
`default_nettype none
// ============================================================================
// Module      : mem_resp
// Description : MEM-stage memory access control and load-return stage.
//               Holds one request at a time, drives the data bus through a
//               req/addr_ok/data_ok handshake, aligns and extends load data
//               (including LWL/LWR merge with the old rt value) and hands
//               the result to WB over a valid/ready handshake. A flush
//               cancels any outstanding transaction and drops its response.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_resp (
   input  logic        clk,
   input  logic        resetn,
   input  logic        flush,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic        res_from_mem,
   input  logic        res_to_mem,
   input  logic [6:0]  load_op,
   input  logic [31:0] mem_addr,
   input  logic [31:0] rt_old,
   input  logic        mem_ex,
   input  logic        req_wr,
   input  logic [1:0]  req_size,
   input  logic [3:0]  req_wstrb,
   input  logic [31:0] req_vaddr,
   input  logic [31:0] req_wdata,
   output logic        data_req,
   output logic        data_wr,
   output logic [1:0]  data_size,
   output logic [3:0]  data_wstrb,
   output logic [31:0] data_addr,
   output logic [31:0] data_wdata,
   input  logic        data_addr_ok,
   input  logic        data_data_ok,
   input  logic [31:0] data_rdata,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_rdata
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_REQ   = 3'd1,
      S_WAIT  = 3'd2,
      S_DONE  = 3'd3,
      S_CREQ  = 3'd4,
      S_DRAIN = 3'd5
   } state_t;

   state_t      r_state;
   state_t      w_next;
   logic        r_data_req;
   logic        r_out_valid;
   logic        r_wr;
   logic [1:0]  r_size;
   logic [3:0]  r_wstrb;
   logic [31:0] r_addr;
   logic [31:0] r_wdata;
   logic [6:0]  r_load_op;
   logic [1:0]  r_a;
   logic [31:0] r_rt;
   logic        r_is_load;
   logic [31:0] r_out_rdata;

   logic        w_accept;
   logic        w_is_mem;
   logic [7:0]  w_byte;
   logic [15:0] w_half;
   logic [31:0] w_load;
   logic        w_unused;

   // Only the byte offset of the effective address matters for alignment.
   assign w_unused = ^{mem_addr[31:2], 1'b0};

   assign w_is_mem = (res_from_mem | res_to_mem) & ~mem_ex;
   assign in_ready = ~flush & ((r_state == S_IDLE) |
                               ((r_state == S_DONE) & out_ready));
   assign w_accept = in_valid & in_ready;

   assign data_req   = r_data_req;
   assign data_wr    = r_wr;
   assign data_size  = r_size;
   assign data_wstrb = r_wstrb;
   assign data_addr  = r_addr;
   assign data_wdata = r_wdata;
   assign out_valid  = r_out_valid;
   assign out_rdata  = r_out_rdata;

   // Next-state decision; flush never withdraws a request before addr_ok.
   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE: begin
            if (w_accept) w_next = w_is_mem ? S_REQ : S_DONE;
         end
         S_REQ: begin
            if (data_addr_ok) w_next = flush ? S_DRAIN : S_WAIT;
            else if (flush)   w_next = S_CREQ;
         end
         S_WAIT: begin
            if (flush)             w_next = S_DRAIN;
            else if (data_data_ok) w_next = S_DONE;
         end
         S_DONE: begin
            if (flush)          w_next = S_IDLE;
            else if (out_ready) w_next = w_accept ? (w_is_mem ? S_REQ : S_DONE)
                                                  : S_IDLE;
         end
         S_CREQ: begin
            if (data_addr_ok) w_next = S_DRAIN;
         end
         S_DRAIN: begin
            if (data_data_ok) w_next = S_IDLE;
         end
         default: w_next = S_IDLE;
      endcase
   end

   // Align and extend returned data according to the captured load type.
   always_comb begin
      w_byte = 8'h00;
      case (r_a)
         2'd0: w_byte = data_rdata[7:0];
         2'd1: w_byte = data_rdata[15:8];
         2'd2: w_byte = data_rdata[23:16];
         2'd3: w_byte = data_rdata[31:24];
         default: w_byte = 8'h00;
      endcase
      w_half = r_a[1] ? data_rdata[31:16] : data_rdata[15:0];
      w_load = 32'h0;
      if (r_load_op[0])      w_load = {{24{w_byte[7]}}, w_byte};
      else if (r_load_op[1]) w_load = {24'h0, w_byte};
      else if (r_load_op[2]) w_load = {{16{w_half[15]}}, w_half};
      else if (r_load_op[3]) w_load = {16'h0, w_half};
      else if (r_load_op[4]) w_load = data_rdata;
      else if (r_load_op[5]) begin
         case (r_a)
            2'd0: w_load = {data_rdata[7:0],  r_rt[23:0]};
            2'd1: w_load = {data_rdata[15:0], r_rt[15:0]};
            2'd2: w_load = {data_rdata[23:0], r_rt[7:0]};
            default: w_load = data_rdata;
         endcase
      end
      else if (r_load_op[6]) begin
         case (r_a)
            2'd0: w_load = data_rdata;
            2'd1: w_load = {r_rt[31:24], data_rdata[31:8]};
            2'd2: w_load = {r_rt[31:16], data_rdata[31:16]};
            default: w_load = {r_rt[31:8], data_rdata[31:24]};
         endcase
      end
   end

   // State, registered flags, captured request fields and load result.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_state     <= S_IDLE;
         r_data_req  <= 1'b0;
         r_out_valid <= 1'b0;
         r_wr        <= 1'b0;
         r_size      <= 2'd0;
         r_wstrb     <= 4'd0;
         r_addr      <= 32'h0;
         r_wdata     <= 32'h0;
         r_load_op   <= 7'd0;
         r_a         <= 2'd0;
         r_rt        <= 32'h0;
         r_is_load   <= 1'b0;
         r_out_rdata <= 32'h0;
      end else begin
         r_state     <= w_next;
         r_data_req  <= (w_next == S_REQ) || (w_next == S_CREQ);
         r_out_valid <= (w_next == S_DONE);
         if (w_accept) begin
            r_wr        <= req_wr;
            r_size      <= req_size;
            r_wstrb     <= req_wstrb;
            r_addr      <= req_vaddr;
            r_wdata     <= req_wdata;
            r_load_op   <= load_op;
            r_a         <= mem_addr[1:0];
            r_rt        <= rt_old;
            r_is_load   <= res_from_mem;
            r_out_rdata <= 32'h0;
         end else if ((r_state == S_WAIT) && !flush && data_data_ok) begin
            r_out_rdata <= r_is_load ? w_load : 32'h0;
         end
      end
   end

   // A response may only arrive while one is outstanding.
   a_data_ok_legal : assert property (@(posedge clk) disable iff (!resetn)
      data_data_ok |-> ((r_state == S_WAIT) || (r_state == S_DRAIN)));

endmodule
`default_nettype wire

// File: tb/tb_mem_resp.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_resp
// Description : Directed self-checking testbench for mem_resp.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_resp;

   logic        clk = 1'b0;
   logic        resetn;
   logic        flush;
   logic        in_valid;
   logic        in_ready;
   logic        res_from_mem;
   logic        res_to_mem;
   logic [6:0]  load_op;
   logic [31:0] mem_addr;
   logic [31:0] rt_old;
   logic        mem_ex;
   logic        req_wr;
   logic [1:0]  req_size;
   logic [3:0]  req_wstrb;
   logic [31:0] req_vaddr;
   logic [31:0] req_wdata;
   logic        data_req;
   logic        data_wr;
   logic [1:0]  data_size;
   logic [3:0]  data_wstrb;
   logic [31:0] data_addr;
   logic [31:0] data_wdata;
   logic        data_addr_ok;
   logic        data_data_ok;
   logic [31:0] data_rdata;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_rdata;

   int n_chk  = 0;
   int n_pass = 0;

   localparam logic [6:0] c_LB  = 7'b0000001;
   localparam logic [6:0] c_LBU = 7'b0000010;
   localparam logic [6:0] c_LH  = 7'b0000100;
   localparam logic [6:0] c_LHU = 7'b0001000;
   localparam logic [6:0] c_LW  = 7'b0010000;
   localparam logic [6:0] c_LWL = 7'b0100000;
   localparam logic [6:0] c_LWR = 7'b1000000;

   mem_resp u_dut (
      .clk          (clk),
      .resetn       (resetn),
      .flush        (flush),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .res_from_mem (res_from_mem),
      .res_to_mem   (res_to_mem),
      .load_op      (load_op),
      .mem_addr     (mem_addr),
      .rt_old       (rt_old),
      .mem_ex       (mem_ex),
      .req_wr       (req_wr),
      .req_size     (req_size),
      .req_wstrb    (req_wstrb),
      .req_vaddr    (req_vaddr),
      .req_wdata    (req_wdata),
      .data_req     (data_req),
      .data_wr      (data_wr),
      .data_size    (data_size),
      .data_wstrb   (data_wstrb),
      .data_addr    (data_addr),
      .data_wdata   (data_wdata),
      .data_addr_ok (data_addr_ok),
      .data_data_ok (data_data_ok),
      .data_rdata   (data_rdata),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .out_rdata    (out_rdata)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
   endtask

   // Advance to just after the next rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_in();
      flush        = 1'b0;
      in_valid     = 1'b0;
      res_from_mem = 1'b0;
      res_to_mem   = 1'b0;
      load_op      = 7'd0;
      mem_addr     = 32'h0;
      rt_old       = 32'h0;
      mem_ex       = 1'b0;
      req_wr       = 1'b0;
      req_size     = 2'd0;
      req_wstrb    = 4'd0;
      req_vaddr    = 32'h0;
      req_wdata    = 32'h0;
      data_addr_ok = 1'b0;
      data_data_ok = 1'b0;
      data_rdata   = 32'h0;
   endtask

   // Present a load in the current cycle (caller ticks afterwards).
   task automatic put_load(input logic [6:0] op, input logic [31:0] addr, input logic [31:0] rt);
      idle_in();
      in_valid     = 1'b1;
      res_from_mem = 1'b1;
      load_op      = op;
      mem_addr     = addr;
      req_vaddr    = addr;
      req_size     = 2'd2;
      rt_old       = rt;
   endtask

   // Zero-wait load: accept at T, addr_ok at T+1, data_ok at T+2, result at T+3.
   task automatic do_load(input string tag, input logic [6:0] op, input logic [31:0] addr,
                          input logic [31:0] rd, input logic [31:0] rt, input logic [31:0] exp);
      out_ready = 1'b1;
      put_load(op, addr, rt);
      #1 chk({tag, " in_ready"}, {31'd0, in_ready}, 32'd1);
      tick();
      idle_in();
      data_addr_ok = 1'b1;
      #1 chk({tag, " data_req"}, {31'd0, data_req}, 32'd1);
      chk({tag, " data_addr"}, data_addr, addr);
      tick();
      idle_in();
      data_data_ok = 1'b1;
      data_rdata   = rd;
      #1 chk({tag, " early valid"}, {31'd0, out_valid}, 32'd0);
      tick();
      idle_in();
      #1 chk({tag, " out_valid"}, {31'd0, out_valid}, 32'd1);
      chk({tag, " out_rdata"}, out_rdata, exp);
      tick();
   endtask

   initial begin
      idle_in();
      out_ready = 1'b1;
      resetn    = 1'b0;
      #12;
      chk("rst data_req",  {31'd0, data_req},  32'd0);
      chk("rst out_valid", {31'd0, out_valid}, 32'd0);
      chk("rst out_rdata", out_rdata, 32'h0);
      chk("rst in_ready",  {31'd0, in_ready},  32'd1);
      chk("rst data_addr", data_addr, 32'h0);
      tick();
      resetn = 1'b1;
      tick();

      // Aligned loads over a zero-wait bus.
      do_load("lb",     c_LB,  32'h0000_1003, 32'h80FF_1234, 32'h0,          32'hFFFF_FF80);
      do_load("lbu",    c_LBU, 32'h0000_1002, 32'h80FF_1234, 32'h0,          32'h0000_00FF);
      do_load("lh",     c_LH,  32'h0000_1002, 32'h80FF_1234, 32'h0,          32'hFFFF_80FF);
      do_load("lhu",    c_LHU, 32'h0000_1000, 32'h80FF_1234, 32'h0,          32'h0000_1234);
      do_load("lw",     c_LW,  32'h0000_1000, 32'h80FF_1234, 32'h0,          32'h80FF_1234);
      do_load("lwl a1", c_LWL, 32'h0000_1001, 32'hAABB_CCDD, 32'h1122_3344, 32'hCCDD_3344);
      do_load("lwr a2", c_LWR, 32'h0000_1002, 32'hAABB_CCDD, 32'h1122_3344, 32'h1122_AABB);
      do_load("lwl a0", c_LWL, 32'h0000_1000, 32'hAABB_CCDD, 32'h1122_3344, 32'hDD22_3344);
      do_load("lwr a3", c_LWR, 32'h0000_1003, 32'hAABB_CCDD, 32'h1122_3344, 32'h1122_33AA);

      // Store with addr_ok delayed by three cycles.
      idle_in();
      in_valid   = 1'b1;
      res_to_mem = 1'b1;
      req_wr     = 1'b1;
      req_size   = 2'd2;
      req_wstrb  = 4'hF;
      req_vaddr  = 32'h0000_2000;
      mem_addr   = 32'h0000_2000;
      req_wdata  = 32'hDEAD_BEEF;
      tick();
      idle_in();
      for (int i = 0; i < 3; i++) begin
         #1 chk("st data_req",   {31'd0, data_req},   32'd1);
         chk("st data_wr",    {31'd0, data_wr},    32'd1);
         chk("st data_size",  {30'd0, data_size},  32'd2);
         chk("st data_wstrb", {28'd0, data_wstrb}, 32'hF);
         chk("st data_addr",  data_addr,  32'h0000_2000);
         chk("st data_wdata", data_wdata, 32'hDEAD_BEEF);
         chk("st in_ready",   {31'd0, in_ready},   32'd0);
         tick();
      end
      data_addr_ok = 1'b1;
      #1 chk("st req at ok", {31'd0, data_req}, 32'd1);
      tick();
      idle_in();
      data_data_ok = 1'b1;
      data_rdata   = 32'h1234_5678;
      #1 chk("st wait req", {31'd0, data_req}, 32'd0);
      chk("st wait in_ready", {31'd0, in_ready}, 32'd0);
      tick();
      idle_in();
      #1 chk("st out_valid", {31'd0, out_valid}, 32'd1);
      chk("st out_rdata", out_rdata, 32'h0);
      tick();

      // Excepted load completes without touching the bus.
      put_load(c_LW, 32'h0000_3001, 32'h0);
      mem_ex = 1'b1;
      tick();
      idle_in();
      #1 chk("ex data_req",  {31'd0, data_req},  32'd0);
      chk("ex out_valid", {31'd0, out_valid}, 32'd1);
      chk("ex out_rdata", out_rdata, 32'h0);
      tick();

      // Flush while the request is pending: cancel and drain.
      put_load(c_LW, 32'h0000_4000, 32'h0);
      tick();
      idle_in();
      flush = 1'b1;
      #1 chk("fl req", {31'd0, data_req}, 32'd1);
      tick();
      idle_in();
      #1 chk("fl creq req", {31'd0, data_req}, 32'd1);
      chk("fl creq in_ready", {31'd0, in_ready}, 32'd0);
      data_addr_ok = 1'b1;
      tick();
      idle_in();
      #1 chk("fl drain req", {31'd0, data_req}, 32'd0);
      chk("fl drain in_ready", {31'd0, in_ready}, 32'd0);
      tick();
      data_data_ok = 1'b1;
      data_rdata   = 32'hCAFE_F00D;
      #1 chk("fl drain valid", {31'd0, out_valid}, 32'd0);
      tick();
      idle_in();
      #1 chk("fl idle valid", {31'd0, out_valid}, 32'd0);
      chk("fl idle in_ready", {31'd0, in_ready}, 32'd1);

      // Held result under back-pressure, then same-cycle handoff.
      out_ready = 1'b0;
      put_load(c_LHU, 32'h0000_5000, 32'h0);
      tick();
      idle_in();
      data_addr_ok = 1'b1;
      tick();
      idle_in();
      data_data_ok = 1'b1;
      data_rdata   = 32'h80FF_1234;
      tick();
      idle_in();
      for (int i = 0; i < 4; i++) begin
         #1 chk("hold valid", {31'd0, out_valid}, 32'd1);
         chk("hold rdata", out_rdata, 32'h0000_1234);
         chk("hold in_ready", {31'd0, in_ready}, 32'd0);
         tick();
      end
      out_ready = 1'b1;
      in_valid  = 1'b1;
      #1 chk("handoff in_ready", {31'd0, in_ready}, 32'd1);
      tick();
      #1 chk("b2b valid", {31'd0, out_valid}, 32'd1);
      chk("b2b rdata", out_rdata, 32'h0);
      chk("b2b in_ready", {31'd0, in_ready}, 32'd1);
      tick();
      in_valid = 1'b0;
      #1 chk("b2b2 valid", {31'd0, out_valid}, 32'd1);
      tick();
      #1 chk("b2b end valid", {31'd0, out_valid}, 32'd0);

      // Asynchronous reset while waiting for data.
      put_load(c_LW, 32'h0000_6000, 32'h0);
      tick();
      idle_in();
      data_addr_ok = 1'b1;
      tick();
      idle_in();
      resetn = 1'b0;
      #1 chk("arst data_addr", data_addr, 32'h0);
      chk("arst in_ready",  {31'd0, in_ready},  32'd1);
      chk("arst out_valid", {31'd0, out_valid}, 32'd0);
      chk("arst data_req",  {31'd0, data_req},  32'd0);
      tick();
      resetn = 1'b1;
      tick();
      do_load("post rst lw", c_LW, 32'h0000_7000, 32'h0BAD_F00D, 32'h0, 32'h0BAD_F00D);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
`default_nettype wire
